// File: rtl/modport_dut_if.sv
// Command bus for the small register-file command engine.
// master issues cmd/adr/data; slave returns read data, pulses and count.
interface modport_dut_if;
   logic [3:0] cmd;
   logic [3:0] adr;
   logic [3:0] data;
   logic [3:0] rdata;
   logic       rvalid;
   logic       err;
   logic [7:0] cmd_cnt;

   modport master (
      output cmd, adr, data,
      input  rdata, rvalid, err, cmd_cnt
   );

   modport slave (
      input  cmd, adr, data,
      output rdata, rvalid, err, cmd_cnt
   );
endinterface

// File: rtl/modport_dut.sv
// 16x4 register file executing one command per cycle.
// Read data, valid/err pulses and a saturating command count are registered.
module modport_dut #(
   parameter logic [3:0] RESET_VAL = 4'h0
) (
   input logic          clk,
   input logic          rst,
   modport_dut_if.slave bus
);

   typedef enum logic [3:0] {
      C_NOP   = 4'd0,
      C_WRITE = 4'd1,
      C_READ  = 4'd2,
      C_INC   = 4'd3,
      C_DEC   = 4'd4,
      C_AND   = 4'd5,
      C_OR    = 4'd6,
      C_XOR   = 4'd7,
      C_CLEAR = 4'd8,
      C_RMW   = 4'd9
   } cmd_e;

   logic [3:0] mem_q [16];
   logic [3:0] mem_d [16];
   logic [3:0] rdata_q, rdata_d;
   logic       rvalid_q, rvalid_d;
   logic       err_q, err_d;
   logic [7:0] cnt_q, cnt_d;
   logic       counted;
   logic [3:0] cur;

   assign cur = mem_q[bus.adr];

   always_comb begin
      mem_d    = mem_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      cnt_d    = cnt_q;
      counted  = 1'b1;
      // Unknown codes fall to default and are treated as illegal.
      case (bus.cmd)
         C_NOP:   counted = 1'b0;
         C_WRITE: mem_d[bus.adr] = bus.data;
         C_READ: begin
            rdata_d  = cur;
            rvalid_d = 1'b1;
         end
         C_INC:   mem_d[bus.adr] = cur + 4'd1;
         C_DEC:   mem_d[bus.adr] = cur - 4'd1;
         C_AND:   mem_d[bus.adr] = cur & bus.data;
         C_OR:    mem_d[bus.adr] = cur | bus.data;
         C_XOR:   mem_d[bus.adr] = cur ^ bus.data;
         C_CLEAR: begin
            for (int i = 0; i < 16; i++) mem_d[i] = RESET_VAL;
         end
         C_RMW: begin
            rdata_d        = cur;
            rvalid_d       = 1'b1;
            mem_d[bus.adr] = bus.data;
         end
         default: begin
            counted = 1'b0;
            err_d   = 1'b1;
         end
      endcase
      if (counted && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem_q[i] <= RESET_VAL;
         rdata_q  <= 4'h0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= 8'h00;
      end else begin
         mem_q    <= mem_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.rdata   = rdata_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.err     = err_q;
   assign bus.cmd_cnt = cnt_q;

endmodule

// File: tb/tb_modport_dut.sv
// Directed bench for modport_dut: each command is applied for one cycle
// and the registered outputs are compared 1 ns after the sampling edge.
module tb_modport_dut;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   modport_dut_if bus ();

   modport_dut #(.RESET_VAL(4'h0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [3:0] c, input logic [3:0] a,
                        input logic [3:0] d);
      bus.cmd  = c;
      bus.adr  = a;
      bus.data = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      issue(4'd0, 4'd0, 4'd0);
      issue(4'd1, 4'd7, 4'd5);
      check("rst_rdata", {4'h0, bus.rdata}, 8'h00);
      check("rst_rvalid", {7'h0, bus.rvalid}, 8'h00);
      check("rst_err", {7'h0, bus.err}, 8'h00);
      check("rst_cnt", bus.cmd_cnt, 8'h00);
      rst = 1'b0;

      for (int a = 0; a < 16; a++) begin
         issue(4'd2, 4'(a), 4'd0);
         check($sformatf("init_rd%0d", a), {4'h0, bus.rdata}, 8'h00);
         check($sformatf("init_rv%0d", a), {7'h0, bus.rvalid}, 8'h01);
      end
      check("init_cnt", bus.cmd_cnt, 8'd16);
      issue(4'd0, 4'd0, 4'd0);
      check("nop_rvalid", {7'h0, bus.rvalid}, 8'h00);

      issue(4'd1, 4'd3, 4'd9);
      check("wr_rvalid", {7'h0, bus.rvalid}, 8'h00);
      issue(4'd2, 4'd3, 4'd0);
      check("b2b_rdata", {4'h0, bus.rdata}, 8'h09);
      check("b2b_rvalid", {7'h0, bus.rvalid}, 8'h01);
      issue(4'd0, 4'd0, 4'd0);
      check("pulse_clr", {7'h0, bus.rvalid}, 8'h00);
      check("rdata_hold", {4'h0, bus.rdata}, 8'h09);
      check("cnt18", bus.cmd_cnt, 8'd18);

      issue(4'd1, 4'd5, 4'd15);
      issue(4'd3, 4'd5, 4'd0);
      issue(4'd2, 4'd5, 4'd0);
      check("inc_wrap", {4'h0, bus.rdata}, 8'h00);
      issue(4'd4, 4'd5, 4'd0);
      issue(4'd2, 4'd5, 4'd0);
      check("dec_wrap", {4'h0, bus.rdata}, 8'h0F);

      issue(4'd1, 4'd2, 4'b1100);
      issue(4'd7, 4'd2, 4'b1010);
      issue(4'd9, 4'd2, 4'd7);
      check("rmw_old", {4'h0, bus.rdata}, 8'h06);
      check("rmw_rvalid", {7'h0, bus.rvalid}, 8'h01);
      issue(4'd2, 4'd2, 4'd0);
      check("rmw_new", {4'h0, bus.rdata}, 8'h07);

      issue(4'd1, 4'd4, 4'hC);
      issue(4'd5, 4'd4, 4'h6);
      issue(4'd6, 4'd4, 4'h3);
      issue(4'd2, 4'd4, 4'd0);
      check("and_or", {4'h0, bus.rdata}, 8'h07);
      check("cnt31", bus.cmd_cnt, 8'd31);

      issue(4'd12, 4'd2, 4'd0);
      check("ill_err", {7'h0, bus.err}, 8'h01);
      check("ill_rvalid", {7'h0, bus.rvalid}, 8'h00);
      check("ill_rdata", {4'h0, bus.rdata}, 8'h07);
      check("ill_cnt", bus.cmd_cnt, 8'd31);
      issue(4'd15, 4'd4, 4'd0);
      check("ill15_err", {7'h0, bus.err}, 8'h01);
      issue(4'd0, 4'd0, 4'd0);
      check("err_clr", {7'h0, bus.err}, 8'h00);
      issue(4'd2, 4'd2, 4'd0);
      check("ill_mem", {4'h0, bus.rdata}, 8'h07);

      issue(4'd8, 4'd0, 4'd0);
      check("clr_cnt", bus.cmd_cnt, 8'd33);
      issue(4'd2, 4'd4, 4'd0);
      check("clr_rd4", {4'h0, bus.rdata}, 8'h00);
      issue(4'd2, 4'd3, 4'd0);
      check("clr_rd3", {4'h0, bus.rdata}, 8'h00);

      rst = 1'b1;
      issue(4'd1, 4'd1, 4'd6);
      rst = 1'b0;
      issue(4'd2, 4'd1, 4'd0);
      check("rstwr_rdata", {4'h0, bus.rdata}, 8'h00);
      check("rstwr_cnt", bus.cmd_cnt, 8'd1);

      for (int i = 0; i < 254; i++) issue(4'd3, 4'd0, 4'd0);
      check("sat_reach", bus.cmd_cnt, 8'd255);
      issue(4'd3, 4'd0, 4'd0);
      check("sat_hold", bus.cmd_cnt, 8'd255);
      issue(4'd2, 4'd0, 4'd0);
      check("inc255_rd", {4'h0, bus.rdata}, 8'h0F);
      check("sat_hold2", bus.cmd_cnt, 8'd255);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/modport_dut.md
MODPORT_DUT -- requirements
Module: modport_dut

Interface
REQ-001 Parameter RESET_VAL, default 4'h0: value loaded into every register-file entry on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 cmd  input  4  command code, sampled every rising edge of clk.
REQ-005 adr  input  4  register-file address, 0..15.
REQ-006 data  input  4  write or operand data.
REQ-007 rdata  output  4  registered read data.
REQ-008 rvalid  output  1  one-cycle pulse when rdata is valid.
REQ-009 err  output  1  one-cycle pulse on an illegal command code.
REQ-010 cmd_cnt  output  8  count of legal non-NOP commands executed; saturates at 255.

Function
REQ-011 Storage is 16 entries x 4 bits, indexed by adr.
REQ-012 cmd 0 (NOP): no state change other than the output pulse clears in REQ-022.
REQ-013 cmd 1 (WRITE): mem[adr] <= data.
REQ-014 cmd 2 (READ): rdata <= mem[adr]; rvalid <= 1.
REQ-015 cmd 3 (INC): mem[adr] <= mem[adr]+1, modulo 16; 15 wraps to 0.
REQ-016 cmd 4 (DEC): mem[adr] <= mem[adr]-1, modulo 16; 0 wraps to 15.
REQ-017 cmd 5/6/7 (AND/OR/XOR): mem[adr] <= mem[adr] op data.
REQ-018 cmd 8 (CLEAR): all 16 entries <= RESET_VAL in one cycle; adr ignored.
REQ-019 cmd 9 (RMW_READ): rdata <= old mem[adr]; mem[adr] <= data; rvalid <= 1.
REQ-020 cmd 10..15: illegal; err <= 1 for one cycle; no storage, rdata or cmd_cnt change.
REQ-021 Each command takes effect at the rising edge where it is sampled. rdata, rvalid and err become visible the same edge, i.e. one cycle of latency after input setup.
REQ-022 rvalid and err are 0 in any cycle whose sampled command did not set them; rdata holds its last value otherwise.
REQ-023 Back-to-back commands to the same adr see the previous command's result: WRITE at cycle N, then READ at N+1, returns the written data.
REQ-024 cmd_cnt increments by 1 for cmd 1..9; it does not change for NOP or illegal codes; it holds at 255.
REQ-025 X or Z on cmd is treated as illegal (err <= 1), and storage is unchanged.
REQ-026 No handshake: the block accepts one command every cycle, with no backpressure.

Reset
REQ-027 While rst=1 at a rising edge: all mem entries <= RESET_VAL; rdata <= 0; rvalid <= 0; err <= 0; cmd_cnt <= 0.
REQ-028 Reset overrides any command sampled in the same cycle; that command is discarded.
REQ-029 The first command after reset is accepted on the first rising edge with rst=0.

Verification
REQ-030 Reset, then READ every adr 0..15 -> rdata=RESET_VAL (0), rvalid pulses 16 times, cmd_cnt=16.
REQ-031 WRITE adr=3 data=9, then READ adr=3 on the next cycle -> rdata=9, rvalid=1 for exactly one cycle.
REQ-032 WRITE adr=5 data=15, INC adr=5, READ adr=5 -> rdata=0; then DEC adr=5, READ adr=5 -> rdata=15.
REQ-033 WRITE adr=2 data=4'b1100, XOR adr=2 data=4'b1010, RMW_READ adr=2 data=7, READ adr=2 -> RMW_READ gives rdata=4'b0110, final READ gives rdata=7.
REQ-034 Issue cmd=12 -> err=1 for one cycle; mem, rdata and cmd_cnt unchanged. Then CLEAR followed by READ of any adr -> rdata=0.
REQ-035 WRITE adr=1 data=6 with rst=1 in the same cycle, then READ adr=1 -> rdata=0 and cmd_cnt=1.
